// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one 32-bit schedule word per clock,
// full round-key store with a round-indexed (optionally registered) read port.

module sub_tableforkey (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [10:0] base;
  assign base = 11'd2047 - {a, 3'b000};
  assign y    = SBOX[base -: 8];
endmodule

module aes_key_expander #(
  parameter int MAX_KEY_BITS = 256,
  parameter bit RK_OUT_REG   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         err,
  output logic [3:0]   nr,
  input  logic [3:0]   rk_sel,
  output logic [127:0] rk_out
);
  localparam int NW = (MAX_KEY_BITS >= 256) ? 60 : (MAX_KEY_BITS >= 192) ? 52 : 44;
  localparam logic [5:0] NW6 = 6'(NW);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state;
  logic [1:0]  mode_r;
  logic [5:0]  i;
  logic [2:0]  kpos;
  logic [7:0]  rcon;
  logic [31:0] w [NW];

  logic [3:0]  nk_c;
  logic [3:0]  nr_c;
  logic [5:0]  last_c;
  logic [31:0] prev;
  logic [31:0] back;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] w_new;
  logic        accept;

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic mode_ok(input logic [1:0] m);
    return (m != 2'b11) && ((128 + 64 * int'(m)) <= MAX_KEY_BITS);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Out-of-store indices read as zero so idle-time index arithmetic stays harmless.
  function automatic logic [31:0] rd(input logic [5:0] idx);
    return (idx < NW6) ? w[idx] : 32'h0;
  endfunction

  always_comb begin
    case (mode_r)
      2'b00:   begin nk_c = 4'd4; nr_c = 4'd10; last_c = 6'd43; end
      2'b01:   begin nk_c = 4'd6; nr_c = 4'd12; last_c = 6'd51; end
      default: begin nk_c = 4'd8; nr_c = 4'd14; last_c = 6'd59; end
    endcase
  end

  assign accept = (state == IDLE) && start && mode_ok(mode);

  assign prev   = rd(i - 6'd1);
  assign back   = rd(i - {2'b00, nk_c});
  assign sub_in = (kpos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  // Four shared S-boxes serve both the RotWord and the AES-256 mid-group SubWord.
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sub_tableforkey u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  always_comb begin
    temp = prev;
    if (kpos == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (nk_c == 4'd8 && kpos == 3'd4)
      temp = sub_out;
  end

  assign w_new = back ^ temp;

  // Schedule control: key load in IDLE, one word per cycle in EXPAND.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      keys_valid <= 1'b0;
      nr         <= 4'd0;
      mode_r     <= 2'b00;
      i          <= 6'd0;
      kpos       <= 3'd0;
      rcon       <= 8'h01;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mode_r     <= mode;
            i          <= {2'b00, nk_of(mode)};
            kpos       <= 3'd0;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        EXPAND: begin
          kpos <= ({1'b0, kpos} == nk_c - 4'd1) ? 3'd0 : kpos + 3'd1;
          if (kpos == 3'd0)
            rcon <= xtime(rcon);
          // done is registered one word early so it is high while w[T-1] is written.
          if (i == last_c - 6'd1)
            done <= 1'b1;
          if (i == last_c) begin
            keys_valid <= 1'b1;
            nr         <= nr_c;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            i <= i + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < 8; k++)
          if (k < int'(nk_of(mode)))
            w[k] <= key_in[255 - 32*k -: 32];
      end else if (state == EXPAND) begin
        w[i] <= w_new;
      end
    end
  end

  // Round-key read port.
  logic [5:0]   rk_base;
  logic         rk_hit;
  logic [127:0] rk_c;

  assign rk_hit  = keys_valid && (rk_sel <= nr);
  assign rk_base = rk_hit ? {rk_sel, 2'b00} : 6'd0;
  assign rk_c    = rk_hit ? {rd(rk_base), rd(rk_base + 6'd1), rd(rk_base + 6'd2),
                             rd(rk_base + 6'd3)} : 128'h0;

  if (RK_OUT_REG) begin : g_rk_reg
    always_ff @(posedge clk) begin
      if (rst) rk_out <= 128'h0;
      else     rk_out <= rk_c;
    end
  end else begin : g_rk_comb
    assign rk_out = rk_c;
  end
endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative, parametrised successor to the single-round combinational key-schedule step.
- Expands an AES-128, AES-192 or AES-256 cipher key into the full round-key set, computing one 32-bit schedule word per clock.
- Stores all round keys internally and serves them to the cipher datapath through a registered, round-indexed read port.
- Sits between key-load logic and the round engine; the round engine reads key N while encrypting round N.

Parameters:
- MAX_KEY_BITS, 256, largest supported key size (128, 192 or 256). Sizes the word store at 44, 52 or 60 words. Modes above this are rejected.
- RK_OUT_REG, 1, 1 = round-key read data registered (1-cycle latency); 0 = combinational read.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to expand key_in under mode
- mode  in  2  00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal
- key_in  in  256  cipher key, left-aligned; a 128-bit key is in [255:128], a 192-bit key in [255:64]
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when the last word is written
- keys_valid  out  1  round-key store holds a complete schedule for nr
- err  out  1  one-cycle pulse on a rejected start
- nr  out  4  round count of the stored schedule: 10, 12 or 14
- rk_sel  in  4  round-key index, 0..nr
- rk_out  out  128  round key rk_sel = words {w[4s], w[4s+1], w[4s+2], w[4s+3]}, w[4s] in [127:96]

Behaviour:
- Reset: busy=0, done=0, err=0, keys_valid=0, nr=0, rk_out=0, FSM=IDLE. The word store is not cleared.
- Key and round parameters: Nk=4/6/8 and Nr=10/12/14 for mode 00/01/10. Total words T=4*(Nr+1), giving 44/52/60.
- FSM IDLE:
  - Legal start with mode ≤ max: latch mode, write w[0..Nk-1] from key_in in the same edge, i<=Nk, rcon<=8'h01, keys_valid<=0. Go to EXPAND next cycle.
  - Start with mode=11, or a mode needing more than MAX_KEY_BITS: err=1 for one cycle, all other state unchanged.
- FSM EXPAND, one word per cycle, busy=1:
  - temp=w[i-1].
  - If i mod Nk==0: temp=SubWord(RotWord(temp))^{rcon,24'h0}, then rcon<=xtime(rcon) (01,02,..,80,1b,36).
  - Else if Nk==8 and i mod 8==4: temp=SubWord(temp).
  - w[i]=w[i-Nk]^temp, then i<=i+1.
  - On writing w[T-1]: done=1 that cycle, keys_valid<=1, nr<=Nr, busy<=0, return to IDLE.
- SubWord uses exactly four sub_tableforkey byte S-box instances, shared by both SubWord cases. RotWord is the left byte-rotate {b2,b1,b0,b3}.
- Latency: start at cycle 0 → done high at cycle T-Nk, which is 40/46/52 for 128/192/256. keys_valid is high from cycle T-Nk+1.
- start while busy: ignored, no err pulse.
- start in IDLE with keys_valid=1: accepted; keys_valid drops on the accepting edge and the old schedule is no longer valid.
- Read port:
  - With RK_OUT_REG=1, rk_out updates one cycle after rk_sel.
  - rk_out=0 if keys_valid=0 or rk_sel>nr.
  - The port is readable only when keys_valid=1. Reads during EXPAND return 0.
- rst mid-EXPAND: FSM to IDLE next edge, busy/done/keys_valid=0. No partial schedule is exposed.
- i and the word index wrap nowhere: the counter is 6 bits and stops at T-1.

Test Plan:
- AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - done exactly 40 cycles after start.
  - rk_sel=10 → d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - rk_sel=0 → the key itself.
  - nr=10.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - done after 46 cycles.
  - rk_sel=12 → e98ba06f 448c773c 8ecc7204 01002202.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - done after 52 cycles.
  - rk_sel=14 → fe4890d1 e6188d0b 046df344 706c631e.
  - rk_sel=15 → 0.
- mode=11 start → one-cycle err, busy stays 0, keys_valid unchanged.
- MAX_KEY_BITS=128 with mode=10 → err, no expansion.
- Second start during AES-128 expansion at cycle 20 → ignored, done still at cycle 40 with the original vector.
- rst asserted at cycle 15 of AES-256 expansion:
  - next cycle busy=0, keys_valid=0, rk_out=0.
  - New AES-128 start then completes correctly at the 40-cycle mark.
